// File: rtl/msrv32_pc_fetch_if.sv
// Instruction-memory request bus between the fetch stage (master) and a
// synchronous instruction memory (slave): address out, ready back.
interface msrv32_pc_fetch_if;
  logic [31:0] i_addr_out;
  logic        i_ready_in;

  modport master (output i_addr_out, input  i_ready_in);
  modport slave  (input  i_addr_out, output i_ready_in);
endinterface

// File: rtl/msrv32_pc_fetch.sv
// Program counter and instruction fetch: selects the next fetch address
// (trap, mret, branch, sequential) and holds it across imem back-pressure.
module msrv32_pc_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter bit          C_EXT     = 1'b0
) (
  input  logic                      ms_riscv32_mp_clk_in,
  input  logic                      ms_riscv32_mp_rst_in,
  input  logic                      branch_taken_in,
  input  logic [31:0]               iadder_in,
  input  logic                      trap_taken_in,
  input  logic [31:0]               trap_address_in,
  input  logic                      mret_in,
  input  logic [31:0]               epc_in,
  msrv32_pc_fetch_if.master         imem,
  output logic [31:0]               pc_out,
  output logic [31:0]               pc_plus_4_out,
  output logic                      instr_valid_out,
  output logic                      misaligned_instr_out
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] held_q;
  logic        valid_q;

  logic [31:0] trap_vec;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic [31:0] issue_addr;

  // Alignment bits the address selection deliberately drops.
  logic unused_bits;
  assign unused_bits = &{1'b0, trap_address_in[1:0], iadder_in[0]};

  assign trap_vec  = {trap_address_in[31:2], 2'b00};
  assign br_target = {iadder_in[31:1], 1'b0};
  assign seq_pc    = pc_q + 32'd4;

  // Redirects only count when the instruction presented to execute is real.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    next_pc = seq_pc;
    if (valid_q) begin
      if (trap_taken_in)        next_pc = trap_vec;
      else if (mret_in)         next_pc = epc_in;
      else if (branch_taken_in) next_pc = br_target;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue_addr = BOOT_ADDR;
    case (state_q)
      S_BOOT: begin
        issue_addr = BOOT_ADDR;
        if (imem.i_ready_in) state_d = S_RUN;
      end
      S_RUN: begin
        issue_addr = next_pc;
        if (!imem.i_ready_in) state_d = S_STALL;
      end
      S_STALL: begin
        // A trap during a stall replaces the held address, and is issued at
        // once so an accepting memory sees the vector in the same cycle.
        issue_addr = trap_taken_in ? trap_vec : held_q;
        if (imem.i_ready_in) state_d = S_RUN;
      end
      default: begin
        state_d    = S_BOOT;
        issue_addr = BOOT_ADDR;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= S_BOOT;
      pc_q    <= BOOT_ADDR;
      held_q  <= BOOT_ADDR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (imem.i_ready_in) begin
        pc_q    <= issue_addr;
        valid_q <= 1'b1;
      end else begin
        held_q  <= issue_addr;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem.i_addr_out     = issue_addr;
  assign pc_out              = pc_q;
  assign pc_plus_4_out       = seq_pc;
  assign instr_valid_out     = valid_q;
  assign misaligned_instr_out = valid_q & branch_taken_in & ~trap_taken_in & ~mret_in
                                & iadder_in[1] & ~C_EXT;

endmodule

// File: tb/tb_msrv32_pc_fetch.sv
// Bench for msrv32_pc_fetch: directed vector table on a C_EXT=0 instance,
// then random stimulus on that and a C_EXT=1 instance against a reference model.
module tb_msrv32_pc_fetch;

  localparam logic [31:0] BOOT_A = 32'h0000_0000;
  localparam logic [31:0] BOOT_B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        br, trap, mret;
  logic [31:0] iadder, taddr, epc;

  logic [31:0] pc_a, pc4_a, pc_b, pc4_b;
  logic        valid_a, mis_a, valid_b, mis_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msrv32_pc_fetch_if bus_a ();
  msrv32_pc_fetch_if bus_b ();
  assign bus_a.i_ready_in = ready;
  assign bus_b.i_ready_in = ready;

  msrv32_pc_fetch #(.BOOT_ADDR(BOOT_A), .C_EXT(1'b0)) dut_a (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .branch_taken_in      (br),
    .iadder_in            (iadder),
    .trap_taken_in        (trap),
    .trap_address_in      (taddr),
    .mret_in              (mret),
    .epc_in               (epc),
    .imem                 (bus_a),
    .pc_out               (pc_a),
    .pc_plus_4_out        (pc4_a),
    .instr_valid_out      (valid_a),
    .misaligned_instr_out (mis_a)
  );

  msrv32_pc_fetch #(.BOOT_ADDR(BOOT_B), .C_EXT(1'b1)) dut_b (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .branch_taken_in      (br),
    .iadder_in            (iadder),
    .trap_taken_in        (trap),
    .trap_address_in      (taddr),
    .mret_in              (mret),
    .epc_in               (epc),
    .imem                 (bus_b),
    .pc_out               (pc_b),
    .pc_plus_4_out        (pc4_b),
    .instr_valid_out      (valid_b),
    .misaligned_instr_out (mis_b)
  );

  typedef struct {
    bit          rst_n, ready, br, trap, mret;
    logic [31:0] iadder, taddr, epc;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] e_iaddr, e_pc;
    bit          e_valid, e_mis;
  } vec_t;

  // Reference view: the address offered to memory persists until accepted;
  // an accepted address becomes the PC presented one cycle later.
  typedef struct {
    bit          booting, waiting, valid;
    logic [31:0] pc, pending;
  } model_t;

  model_t ma, mb;
  vec_t   tbl[$];

  function automatic logic [31:0] model_issue(input model_t m, input logic [31:0] boot);
    if (m.booting) return boot;
    if (m.waiting) return trap ? (taddr & ~32'd3) : m.pending;
    if (trap)      return taddr & ~32'd3;
    if (mret)      return epc;
    if (br)        return iadder & ~32'd1;
    return m.pc + 32'd4;
  endfunction

  function automatic bit model_mis(input model_t m, input bit c_ext);
    return m.valid && br && !trap && !mret && iadder[1] && !c_ext;
  endfunction

  function automatic model_t model_next(input model_t m, input logic [31:0] boot);
    model_t      n = m;
    logic [31:0] a = model_issue(m, boot);
    if (!rst_n) begin
      n.booting = 1'b1; n.waiting = 1'b0; n.valid = 1'b0;
      n.pc = boot; n.pending = boot;
    end else if (ready) begin
      n.booting = 1'b0; n.waiting = 1'b0; n.valid = 1'b1; n.pc = a;
    end else begin
      n.valid = 1'b0;
      if (!m.booting) begin
        n.waiting = 1'b1; n.pending = a;
      end
    end
    return n;
  endfunction

  function automatic vec_t mk(input bit r, input bit rdy, input bit b, input logic [31:0] ia,
                              input bit t, input logic [31:0] ta, input bit m, input logic [31:0] e,
                              input logic [31:0] x_iaddr, input logic [31:0] x_pc,
                              input bit x_valid, input bit x_mis);
    vec_t v;
    v.s.rst_n = r; v.s.ready = rdy; v.s.br = b; v.s.iadder = ia;
    v.s.trap = t; v.s.taddr = ta; v.s.mret = m; v.s.epc = e;
    v.e_iaddr = x_iaddr; v.e_pc = x_pc; v.e_valid = x_valid; v.e_mis = x_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input stim_t s);
    @(negedge clk);
    rst_n = s.rst_n; ready = s.ready; br = s.br; iadder = s.iadder;
    trap = s.trap; taddr = s.taddr; mret = s.mret; epc = s.epc;
    #1;
  endtask

  task automatic commit();
    ma = model_next(ma, BOOT_A);
    mb = model_next(mb, BOOT_B);
    @(posedge clk);
  endtask

  task automatic check_a_model(input string tag);
    check({tag, "_a_iaddr"}, bus_a.i_addr_out, model_issue(ma, BOOT_A));
    check({tag, "_a_pc"},    pc_a,    ma.pc);
    check({tag, "_a_pc4"},   pc4_a,   ma.pc + 32'd4);
    check({tag, "_a_valid"}, 32'(valid_a), 32'(ma.valid));
    check({tag, "_a_mis"},   32'(mis_a),   32'(model_mis(ma, 1'b0)));
  endtask

  task automatic check_b_model(input string tag);
    check({tag, "_b_iaddr"}, bus_b.i_addr_out, model_issue(mb, BOOT_B));
    check({tag, "_b_pc"},    pc_b,    mb.pc);
    check({tag, "_b_pc4"},   pc4_b,   mb.pc + 32'd4);
    check({tag, "_b_valid"}, 32'(valid_b), 32'(mb.valid));
    check({tag, "_b_mis"},   32'(mis_b),   32'(model_mis(mb, 1'b1)));
  endtask

  initial begin
    stim_t s;
    ma = '{default: '0};
    mb = '{default: '0};
    rst_n = 1'b0; ready = 1'b1; br = 1'b0; trap = 1'b0; mret = 1'b0;
    iadder = '0; taddr = '0; epc = '0;

    // Reset held low for three cycles, ready high throughout.
    s = '{rst_n: 1'b0, ready: 1'b1, br: 1'b0, trap: 1'b0, mret: 1'b0,
          iadder: 32'h0, taddr: 32'h0, epc: 32'h0};
    for (int i = 0; i < 3; i++) begin
      drive(s);
      if (i == 2) begin
        check("rst_iaddr", bus_a.i_addr_out, BOOT_A);
        check("rst_pc",    pc_a,  BOOT_A);
        check("rst_pc4",   pc4_a, BOOT_A + 32'd4);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_pc_b",  pc_b,  BOOT_B);
      end
      commit();
    end

    //           rst rdy br iadder          trap taddr        mret epc     | iaddr          pc             v  mis
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h0,         32'h0,         0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h4,         32'h0,         1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h100,        0, 32'h0,     0, 32'h0,   32'h100,       32'h4,         1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h201,        0, 32'h0,     0, 32'h0,   32'h200,       32'h100,       1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h100,        0, 32'h0,     0, 32'h0,   32'h100,       32'h200,       1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h202,        1, 32'h83,    0, 32'h0,   32'h80,        32'h100,       1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h202,        0, 32'h83,    0, 32'h0,   32'h202,       32'h80,        1, 1));
    tbl.push_back(mk(1, 1, 1, 32'h300,        1, 32'h80,    1, 32'h400, 32'h80,        32'h202,       1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h300,        0, 32'h0,     1, 32'h400, 32'h400,       32'h80,        1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h10,         0, 32'h0,     0, 32'h0,   32'h10,        32'h400,       1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h300,        0, 32'h0,     0, 32'h0,   32'h300,       32'h10,        1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h502,        0, 32'h0,     1, 32'h600, 32'h300,       32'h10,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h300,       32'h10,        0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h300,       32'h10,        0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h304,       32'h300,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h308,       32'h304,       1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          1, 32'h81,    0, 32'h0,   32'h80,        32'h304,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h80,        32'h304,       0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          1, 32'h1F0,   0, 32'h0,   32'h1F0,       32'h304,       0, 0));
    tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,     0, 32'h0,   32'hFFFF_FFFC, 32'h1F0,       1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h0,         32'hFFFF_FFFC, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h4,         32'h0,         1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h8,         32'h4,         1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h8,         32'h4,         0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h0,         32'h0,         0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h302,        1, 32'h80,    0, 32'h0,   32'h0,         32'h0,         0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h0,         32'h0,         0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,     0, 32'h0,   32'h4,         32'h0,         1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].s);
      check($sformatf("row%0d_iaddr", i), bus_a.i_addr_out, tbl[i].e_iaddr);
      check($sformatf("row%0d_pc", i),    pc_a,  tbl[i].e_pc);
      check($sformatf("row%0d_pc4", i),   pc4_a, tbl[i].e_pc + 32'd4);
      check($sformatf("row%0d_valid", i), 32'(valid_a), 32'(tbl[i].e_valid));
      check($sformatf("row%0d_mis", i),   32'(mis_a),   32'(tbl[i].e_mis));
      check_b_model($sformatf("row%0d", i));
      commit();
    end

    // Random traffic: back-pressure, redirects, occasional reset.
    for (int n = 0; n < 1500; n++) begin
      s.rst_n  = ($urandom_range(0, 63) != 0);
      s.ready  = ($urandom_range(0, 3) != 0);
      s.br     = ($urandom_range(0, 9) < 3);
      s.trap   = ($urandom_range(0, 19) == 0);
      s.mret   = ($urandom_range(0, 19) == 0);
      s.iadder = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : $urandom;
      s.taddr  = $urandom;
      s.epc    = $urandom;
      drive(s);
      check_a_model("rnd");
      check_b_model("rnd");
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
